data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 155 +++++++++++++++
 tb/tb_data_mem_responder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Byte-addressable data memory responder with a fixed request-to-response latency.
// Loads, stores and error responses all retire at the same completion edge.
module data_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  stall_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic                  reqWrite_p1;
  logic                  reqUnsigned_p1;
  logic [31:0]           reqAddr_p1;
  logic [1:0]            reqSize_p1;
  logic [DATA_WIDTH-1:0] reqWdata_p1;

  logic [7:0] mem [2**ADDR_WIDTH];

  logic                  accept;
  logic                  doCommit;
  logic                  curWrite;
  logic                  curUnsigned;
  logic [31:0]           curAddr;
  logic [1:0]            curSize;
  logic [DATA_WIDTH-1:0] curWdata;
  logic                  curErr;
  logic [ADDR_WIDTH-1:0] idx0, idx1, idx2, idx3;
  logic [31:0]           rawWord;

  function automatic logic isErr(input logic [31:0] a, input logic [1:0] s);
    isErr = (s == 2'd3) ||
            (s == 2'd1 && a[0]) ||
            (s == 2'd2 && a[1:0] != 2'b00) ||
            ((a >> ADDR_WIDTH) != 32'd0);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] extendLoad(input logic [31:0] raw,
                                                       input logic [1:0]  s,
                                                       input logic        uns);
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    sb = raw[7:0];
    sh = raw[15:0];
    case (s)
      2'd0:    extendLoad = {{(DATA_WIDTH-8){sb[7] & ~uns}}, sb};
      2'd1:    extendLoad = {{(DATA_WIDTH-16){sh[15] & ~uns}}, sh};
      default: extendLoad = DATA_WIDTH'(raw);
    endcase
  endfunction

  assign req_ready = (state != BUSY);
  assign stall_o   = req_valid & ~req_ready;
  assign accept    = req_valid & req_ready;

  // With single-cycle latency the acceptance edge is also the completion edge,
  // so the live request is used instead of the registered copy.
  always_comb begin
    if (LATENCY == 1) begin
      curWrite    = req_write;
      curUnsigned = req_unsigned;
      curAddr     = req_addr;
      curSize     = req_size;
      curWdata    = req_wdata;
      doCommit    = accept;
    end else begin
      curWrite    = reqWrite_p1;
      curUnsigned = reqUnsigned_p1;
      curAddr     = reqAddr_p1;
      curSize     = reqSize_p1;
      curWdata    = reqWdata_p1;
      doCommit    = (state == BUSY) && (cnt == 4'd0);
    end
    curErr  = isErr(curAddr, curSize);
    idx0    = curAddr[ADDR_WIDTH-1:0];
    idx1    = idx0 | ADDR_WIDTH'(1);
    idx2    = idx0 | ADDR_WIDTH'(2);
    idx3    = idx0 | ADDR_WIDTH'(3);
    rawWord = {mem[idx3], mem[idx2], mem[idx1], mem[idx0]};
  end

  // Storage is never cleared; reset only blocks a commit in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (!rst && doCommit && curWrite && !curErr) begin
      mem[idx0] <= curWdata[7:0];
      if (curSize != 2'd0) mem[idx1] <= curWdata[15:8];
      if (curSize == 2'd2) begin
        mem[idx2] <= curWdata[23:16];
        mem[idx3] <= curWdata[31:24];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      reqWrite_p1    <= 1'b0;
      reqUnsigned_p1 <= 1'b0;
      reqAddr_p1     <= 32'd0;
      reqSize_p1     <= 2'd0;
      reqWdata_p1    <= '0;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_err       <= 1'b0;
    end else begin
      // completion stage: response registered from the committing request
      resp_valid <= doCommit;
      resp_err   <= doCommit & curErr;
      resp_rdata <= (doCommit && !curErr && !curWrite) ?
                    extendLoad(rawWord, curSize, curUnsigned) : '0;
      if (accept) begin
        reqWrite_p1    <= req_write;
        reqUnsigned_p1 <= req_unsigned;
        reqAddr_p1     <= req_addr;
        reqSize_p1     <= req_size;
        reqWdata_p1    <= req_wdata;
      end
      case (state)
        BUSY: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        default: begin
          if (accept) begin
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= BUSY;
              cnt   <= (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances (latency 2, 1, 3)
// share one request bus; each test checks the instance it targets.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_write, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;

  logic        rdy2, rv2, err2, st2;
  logic [31:0] rd2;
  logic        rdy1, rv1, err1, st1;
  logic [31:0] rd1;
  logic        rdy3, rv3, err3, st3;
  logic [31:0] rd3;

  int nCmp = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .LATENCY(2)) u2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .req_ready(rdy2), .resp_valid(rv2),
    .resp_rdata(rd2), .resp_err(err2), .stall_o(st2));

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .req_ready(rdy1), .resp_valid(rv1),
    .resp_rdata(rd1), .resp_err(err1), .stall_o(st1));

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .LATENCY(3)) u3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .req_ready(rdy3), .resp_valid(rv3),
    .resp_rdata(rd3), .resp_err(err3), .stall_o(st3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    if (obs !== exp) begin
      nErr++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [1:0] s,
                       input logic u, input logic [31:0] wd);
    req_valid    = 1'b1;
    req_write    = w;
    req_addr     = a;
    req_size     = s;
    req_unsigned = u;
    req_wdata    = wd;
  endtask

  // One isolated request on the latency-2 instance, starting with it idle.
  task automatic l2Txn(input string tag, input logic w, input logic [31:0] a,
                       input logic [1:0] s, input logic u, input logic [31:0] wd,
                       input logic [31:0] expD, input logic expE);
    drive(w, a, s, u, wd);
    chk({tag, ".rdy"}, rdy2, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({tag, ".busy"}, rdy2, 0);
    chk({tag, ".early"}, rv2, 0);
    @(posedge clk); #1;
    chk({tag, ".vld"}, rv2, 1);
    chk({tag, ".data"}, rd2, expD);
    chk({tag, ".err"}, err2, expE);
    chk({tag, ".rdyResp"}, rdy2, 1);
    @(posedge clk); #1;
    chk({tag, ".done"}, rv2, 0);
    chk({tag, ".dz"}, rd2, 0);
  endtask

  logic [31:0] l1Addr [4] = '{32'h10, 32'h20, 32'h21, 32'h10};
  logic [1:0]  l1Size [4] = '{2'd2, 2'd2, 2'd0, 2'd1};
  logic        l1Uns  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] l1Exp  [4] = '{32'hDEADBEEF, 32'h44338011, 32'h00000080, 32'hFFFFBEEF};

  initial begin
    req_valid = 0; req_write = 0; req_addr = 0; req_size = 0;
    req_unsigned = 0; req_wdata = 0;
    repeat (2) @(posedge clk); #1;
    chk("rst.rdy", rdy2, 1);
    chk("rst.vld", rv2, 0);
    chk("rst.data", rd2, 0);
    chk("rst.err", err2, 0);
    chk("rst.stall", st2, 0);
    rst = 1'b0;

    // word store / load round trip
    l2Txn("stw10", 1, 32'h10, 2'd2, 0, 32'hDEADBEEF, 32'h0, 0);
    l2Txn("ldw10", 0, 32'h10, 2'd2, 0, 32'h0, 32'hDEADBEEF, 0);

    // byte store inside a known word, with both extensions
    l2Txn("stw20", 1, 32'h20, 2'd2, 0, 32'h44332211, 32'h0, 0);
    l2Txn("stb21", 1, 32'h21, 2'd0, 0, 32'hFFFFFF80, 32'h0, 0);
    l2Txn("ldbS", 0, 32'h21, 2'd0, 0, 32'h0, 32'hFFFFFF80, 0);
    l2Txn("ldbU", 0, 32'h21, 2'd0, 1, 32'h0, 32'h00000080, 0);
    l2Txn("ldw20", 0, 32'h20, 2'd2, 0, 32'h0, 32'h44338011, 0);
    l2Txn("ldhS", 0, 32'h10, 2'd1, 0, 32'h0, 32'hFFFFBEEF, 0);
    l2Txn("ldhU", 0, 32'h10, 2'd1, 1, 32'h0, 32'h0000BEEF, 0);

    // error requests, then confirm storage untouched
    l2Txn("errH13", 0, 32'h13, 2'd1, 0, 32'h0, 32'h0, 1);
    l2Txn("errSz3", 0, 32'h10, 2'd3, 0, 32'h0, 32'h0, 1);
    l2Txn("errOob", 0, 32'h1000, 2'd2, 0, 32'h0, 32'h0, 1);
    l2Txn("errStH", 1, 32'h11, 2'd1, 0, 32'h0000AAAA, 32'h0, 1);
    l2Txn("errStW", 1, 32'h1000, 2'd2, 0, 32'h55555555, 32'h0, 1);
    l2Txn("keep10", 0, 32'h10, 2'd2, 0, 32'h0, 32'hDEADBEEF, 0);
    l2Txn("keep20", 0, 32'h20, 2'd2, 0, 32'h0, 32'h44338011, 0);

    // reset while busy aborts the store
    l2Txn("clr40", 1, 32'h40, 2'd2, 0, 32'h0, 32'h0, 0);
    drive(1, 32'h40, 2'd2, 0, 32'h12345678);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort.busy", rdy2, 0);
    rst = 1'b1;
    #1;
    chk("abort.rdy", rdy2, 1);
    chk("abort.vld", rv2, 0);
    chk("abort.data", rd2, 0);
    chk("abort.err", err2, 0);
    chk("abort.stall", st2, 0);
    @(posedge clk); #1;
    chk("abort.vld2", rv2, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort.vld3", rv2, 0);
    l2Txn("ld40", 0, 32'h40, 2'd2, 0, 32'h0, 32'h0, 0);

    // latency 1: held valid streams four loads with no stall
    drive(0, l1Addr[0], l1Size[0], l1Uns[0], 32'h0);
    chk("l1.stall0", st1, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("l1.vld%0d", i), rv1, 1);
      chk($sformatf("l1.data%0d", i), rd1, l1Exp[i]);
      chk($sformatf("l1.err%0d", i), err1, 0);
      if (i < 3) drive(0, l1Addr[i+1], l1Size[i+1], l1Uns[i+1], 32'h0);
      else       req_valid = 1'b0;
      chk($sformatf("l1.stall%0d", i + 1), st1, 0);
    end
    @(posedge clk); #1;
    chk("l1.end", rv1, 0);
    repeat (6) @(posedge clk);
    #1;

    // latency 3: two stall cycles per held request
    drive(0, 32'h10, 2'd2, 0, 32'h0);
    chk("l3.stallIdle", st3, 0);
    for (int r = 0; r < 2; r++) begin
      @(posedge clk); #1;
      chk($sformatf("l3.stallA%0d", r), st3, 1);
      chk($sformatf("l3.early%0d", r), rv3, 0);
      @(posedge clk); #1;
      chk($sformatf("l3.stallB%0d", r), st3, 1);
      @(posedge clk); #1;
      chk($sformatf("l3.vld%0d", r), rv3, 1);
      chk($sformatf("l3.stallR%0d", r), st3, 0);
      chk($sformatf("l3.data%0d", r), rd3, (r == 0) ? 32'hDEADBEEF : 32'h44338011);
      if (r == 0) drive(0, 32'h20, 2'd2, 0, 32'h0);
      else        req_valid = 1'b0;
    end
    @(posedge clk); #1;
    chk("l3.end", rv3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
